// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Sends one command byte to a PS/2 device. The sequence is: inhibit the clock,
// request-to-send, shift out the bits on device clock falling edges, then wait
// for the device acknowledge and for the bus to go idle.
// Optional frame watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk_sync,
  input  logic       kb_data_sync,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  // Both counters compare against (N - 1), so N must be at least one.
  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            parity_q, parity_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]      edge_cnt_q, edge_cnt_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            clk_prev_q;
  logic            fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
`endif

  // A falling edge is the device clock high last cycle and low now.
  assign fall = clk_prev_q & ~kb_clk_sync;

  // State and datapath registers; reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_q     <= 8'h00;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      edge_cnt_q <= 4'd0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_prev_q <= kb_clk_sync;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit presentation and completion pulses.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    parity_d   = parity_q;
    inh_cnt_d  = inh_cnt_q;
    edge_cnt_d = edge_cnt_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        inh_cnt_d  = '0;
        edge_cnt_d = 4'd0;
        data_oe_d  = 1'b0;
        if (tx_start) begin
          byte_d   = tx_data;
          parity_d = ~^tx_data;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          inh_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        // Start bit stays on the line until the first falling edge.
        data_oe_d  = 1'b1;
        edge_cnt_d = 4'd0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q < 4'd8) begin
            data_oe_d = ~byte_q[edge_cnt_q[2:0]];
          end else if (edge_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            // Edge 10: stop bit is a released line; hand over to ACK.
            data_oe_d  = 1'b0;
            edge_cnt_d = 4'd0;
            state_d    = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (fall) begin
          if (kb_data_sync) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (kb_clk_sync && kb_data_sync) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog runs from REQ entry; a frame completing on the same cycle wins.
    wd_cnt_d = '0;
    if (state_q != S_IDLE && state_q != S_INHIBIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_LAST && state_d != S_IDLE) begin
        state_d    = S_IDLE;
        err_d      = 1'b1;
        done_d     = 1'b0;
        data_oe_d  = 1'b0;
        edge_cnt_d = 4'd0;
        wd_cnt_d   = '0;
      end
    end
`endif
  end

  // Bus drivers and status decode straight from registered state.
  always_comb begin
    kb_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    kb_data_oe = 1'b0;
    if (state_q == S_REQ) begin
      kb_data_oe = 1'b1;
    end else if (state_q == S_SEND) begin
      kb_data_oe = data_oe_q;
    end
    tx_busy = (state_q != S_IDLE);
    tx_done = done_q;
    tx_err  = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx
module tb_ps2_host_tx;

  localparam int INH = 300;
  localparam int TO  = 500;
  localparam int HP  = 6;
  localparam int LP  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       kb_clk_sync, kb_data_sync;
  logic       kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_err;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Open-collector bus: either side pulling low wins.
  assign kb_clk_sync  = kb_clk_oe  ? 1'b0 : dev_clk;
  assign kb_data_sync = kb_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .kb_clk_sync(kb_clk_sync), .kb_data_sync(kb_data_sync),
    .tx_data(tx_data), .tx_start(tx_start), .kb_clk_oe(kb_clk_oe),
    .kb_data_oe(kb_data_oe), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
    end
  end

  // Line levels a device should see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic host_start(input logic [7:0] b, output int inh, output int req);
    @(posedge clk); #1;
    tx_data = b;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    inh = 0;
    req = 0;
    @(negedge clk);
    while (kb_clk_oe && !kb_data_oe && inh < INH + 50) begin
      inh++;
      @(negedge clk);
    end
    while (kb_clk_oe && kb_data_oe && req < 10) begin
      req++;
      @(negedge clk);
    end
  endtask

  task automatic device_run(input int n_edges, input bit ack, output logic [10:0] bits);
    bits = '0;
    repeat (HP) @(negedge clk);
    bits[0] = kb_data_sync;
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk); #1;
      if (k == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (LP) @(negedge clk);
      if (k <= 10) bits[k] = kb_data_sync;
      @(posedge clk); #1;
      dev_clk = 1'b1;
      repeat (HP) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n = 0;
    while (tx_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = !tx_busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (kb_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", kb_clk_oe); end
    n_cmp++; if (kb_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", kb_data_oe); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
    n_cmp++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", tx_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_ed;
    int inh, req, d0, e0;
    logic [10:0] bits, exp_bits;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_bits = frame_model(8'hED);
    host_start(8'hED, inh, req);
    device_run(11, 1'b1, bits);
    wait_idle(200, ok);
    n_cmp++; if (inh != INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
    n_cmp++; if (req != 1) begin n_fail++; $display("FAIL ed_req_len: got %0d want 1", req); end
    n_cmp++; if (bits !== exp_bits) begin n_fail++; $display("FAIL ed_frame_bits: got %b want %b", bits, exp_bits); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ed_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL ed_err_pulses: got %0d want 0", err_cnt - e0); end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ed_idle: busy still %b want 0", tx_busy); end
  endtask

  task automatic test_no_ack;
    int inh, req, d0, e0;
    logic [10:0] bits, exp_bits;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_bits = frame_model(8'h00);
    host_start(8'h00, inh, req);
    device_run(11, 1'b0, bits);
    wait_idle(200, ok);
    n_cmp++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL noack_parity: got %b want 1", bits[9]); end
    n_cmp++; if (bits !== exp_bits) begin n_fail++; $display("FAIL noack_frame_bits: got %b want %b", bits, exp_bits); end
    n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL noack_err_pulses: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL noack_done_pulses: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (!ok || kb_clk_oe || kb_data_oe) begin n_fail++; $display("FAIL noack_idle: busy %b clk_oe %b data_oe %b want 0 0 0", tx_busy, kb_clk_oe, kb_data_oe); end
  endtask

  task automatic test_reset_mid_frame;
    int inh, req, d0, e0;
    logic [10:0] bits, exp_bits;
    bit ok;
    exp_bits = frame_model(8'hF4);
    host_start(8'hF4, inh, req);
    device_run(4, 1'b0, bits);
    n_cmp++; if (bits[4:0] !== exp_bits[4:0]) begin n_fail++; $display("FAIL abort_first_bits: got %b want %b", bits[4:0], exp_bits[4:0]); end
    d0 = done_cnt; e0 = err_cnt;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (kb_clk_oe !== 1'b0 || kb_data_oe !== 1'b0) begin n_fail++; $display("FAIL abort_release: clk_oe %b data_oe %b want 0 0", kb_clk_oe, kb_data_oe); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", tx_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_fail++; $display("FAIL abort_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    d0 = done_cnt;
    host_start(8'hF4, inh, req);
    device_run(11, 1'b1, bits);
    wait_idle(200, ok);
    n_cmp++; if (bits !== exp_bits) begin n_fail++; $display("FAIL refr_frame_bits: got %b want %b", bits, exp_bits); end
    n_cmp++; if (done_cnt - d0 != 1 || !ok) begin n_fail++; $display("FAIL refr_done: got %0d pulses busy %b want 1 0", done_cnt - d0, tx_busy); end
  endtask

  task automatic test_back_to_back;
    int inh, req, d0, e0;
    logic [10:0] bits, exp_bits;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_bits = frame_model(8'hED);
    host_start(8'hED, inh, req);
    @(posedge clk); #1;
    tx_data = 8'h55;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    device_run(11, 1'b1, bits);
    wait_idle(200, ok);
    repeat (50) @(negedge clk);
    n_cmp++; if (bits !== exp_bits) begin n_fail++; $display("FAIL b2b_frame_bits: got %b want %b", bits, exp_bits); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL b2b_err_pulses: got %0d want 0", err_cnt - e0); end
    n_cmp++; if (tx_busy || kb_clk_oe) begin n_fail++; $display("FAIL b2b_no_second_frame: busy %b clk_oe %b want 0 0", tx_busy, kb_clk_oe); end
  endtask

  task automatic test_random;
    int inh, req, d0, e0;
    logic [7:0] b;
    logic [10:0] bits, exp_bits;
    bit ack, ok;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      exp_bits = frame_model(b);
      d0 = done_cnt; e0 = err_cnt;
      host_start(b, inh, req);
      device_run(11, ack, bits);
      wait_idle(200, ok);
      n_cmp++; if (bits !== exp_bits) begin n_fail++; $display("FAIL rand_frame_bits[%0h]: got %b want %b", b, bits, exp_bits); end
      n_cmp++; if (done_cnt - d0 != (ack ? 1 : 0) || err_cnt - e0 != (ack ? 0 : 1) || !ok) begin
        n_fail++;
        $display("FAIL rand_outcome[%0h]: done %0d err %0d busy %b want %0d %0d 0", b, done_cnt - d0, err_cnt - e0, tx_busy, ack ? 1 : 0, ack ? 0 : 1);
      end
    end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout;
    int inh, req, n;
    bit ok;
    host_start(8'hA5, inh, req);
    n = 1;
    while (!tx_err && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n != TO) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", n, TO); end
    n_cmp++; if (kb_clk_oe !== 1'b0 || kb_data_oe !== 1'b0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_release: clk_oe %b data_oe %b busy %b want 0 0 0", kb_clk_oe, kb_data_oe, tx_busy);
    end
    wait_idle(10, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_frame_ed();
    test_no_ack();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (both_cnt != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
